// File: rtl/add8_err_meter.sv
// Exhaustive error meter for an 8-bit approximate adder: sweeps all 65536 A/B pairs and accumulates MAE/WCE/error-count statistics.
// Latency: start accept edge to done is 65537 cycles (pair n on dut_a/dut_b after edge E0+n, accumulated at E0+n+2).
// Backpressure: none; the sweep free-runs once started and start is ignored while busy (no queuing).
// Optional: define ADD8_ERR_METER_HD_EN to add Hamming-distance accumulation and the hd_sum port.
module add8_err_meter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  dut_a,
    output logic [7:0]  dut_b,
    input  logic [8:0]  dut_o,
    output logic [24:0] err_sum,
    output logic [8:0]  wce,
    output logic [16:0] err_cnt
`ifdef ADD8_ERR_METER_HD_EN
    ,
    output logic [19:0] hd_sum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;

    // S0: operand counter (A = high byte, B = low byte) and its valid tag
    logic [15:0] r_cnt;
    logic        r_v0;
    logic        r_drain;

    // S1: captured adder result and exact reference
    logic [8:0]  r_o1;
    logic [8:0]  r_ex1;
    logic        r_v1;

    // S2: error magnitude feeding the accumulators
    logic [9:0]  w_err;
    logic [9:0]  w_err_neg;
    logic [8:0]  w_abs;
    logic        w_nz;

    logic [24:0] r_err_sum;
    logic [8:0]  r_wce;
    logic [16:0] r_err_cnt;

    // A start is only honoured when no sweep is in flight
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; RUN hands over to DRAIN on the edge that loads the last pair,
    // so DRAIN covers the two cycles the last pair needs to reach the accumulators.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == 16'hFFFE) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drain) w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand counter, S0 valid tag and drain cycle marker
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_v0    <= 1'b0;
            r_drain <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_v0    <= 1'b1;
            r_drain <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_cnt <= r_cnt + 16'd1;
                    r_v0  <= 1'b1;
                end
                S_DRAIN: begin
                    r_v0    <= 1'b0;
                    r_drain <= 1'b1;
                end
                default: r_v0 <= 1'b0;
            endcase
        end
    end

    // S1: sample the adder output one cycle after the operands change
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o1  <= '0;
            r_ex1 <= '0;
            r_v1  <= 1'b0;
        end else begin
            r_o1  <= dut_o;
            r_ex1 <= {1'b0, r_cnt[15:8]} + {1'b0, r_cnt[7:0]};
            r_v1  <= r_v0 && !w_accept;
        end
    end

    // S2: signed error and its magnitude (range 0..511 fits 9 bits)
    always_comb begin
        w_err     = {1'b0, r_o1} - {1'b0, r_ex1};
        w_err_neg = 10'd0 - w_err;
        w_abs     = w_err[9] ? w_err_neg[8:0] : w_err[8:0];
        w_nz      = (w_abs != 9'd0);
    end

    // Accumulators: cleared by reset or an accepted start, updated only by valid pairs
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_err_sum <= '0;
            r_wce     <= '0;
            r_err_cnt <= '0;
        end else if (r_v1) begin
            r_err_sum <= r_err_sum + {16'd0, w_abs};
            if (w_abs > r_wce) r_wce <= w_abs;
            r_err_cnt <= r_err_cnt + {16'd0, w_nz};
        end
    end

`ifdef ADD8_ERR_METER_HD_EN
    logic [8:0]  w_xdiff;
    logic [3:0]  w_hd;
    logic [19:0] r_hd_sum;

    // Hamming distance between the adder result and the exact sum
    always_comb begin
        w_xdiff = r_o1 ^ r_ex1;
        w_hd    = '0;
        for (int i = 0; i < 9; i++) begin
            w_hd = w_hd + {3'd0, w_xdiff[i]};
        end
    end

    // Hamming-distance accumulator, same clear/update rules as the others
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_hd_sum <= '0;
        end else if (r_v1) begin
            r_hd_sum <= r_hd_sum + {16'd0, w_hd};
        end
    end

    assign hd_sum = r_hd_sum;
`endif

    assign busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done    = (r_state == S_DONE);
    assign dut_a   = r_cnt[15:8];
    assign dut_b   = r_cnt[7:0];
    assign err_sum = r_err_sum;
    assign wce     = r_wce;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_add8_err_meter.sv
// Bench for add8_err_meter: a behavioural adder (exact / tied to zero / LSB-inverted) closes the loop,
// and a reference statistics model fills a scoreboard that is drained when results are observed.
// Define ADD8_ERR_METER_HD_EN to also cover hd_sum.
module tb_add8_err_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  dut_a;
    logic [7:0]  dut_b;
    logic [8:0]  dut_o;
    logic [24:0] err_sum;
    logic [8:0]  wce;
    logic [16:0] err_cnt;
`ifdef ADD8_ERR_METER_HD_EN
    logic [19:0] hd_sum;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;   // 0 exact, 1 output tied to 0, 2 exact with LSB inverted

    typedef struct {
        int es;
        int wce;
        int ec;
        int hd;
    } stats_t;

    stats_t sb_q[$];

    always #5 clk = ~clk;

    // Adder under test
    always_comb begin
        case (mode)
            1:       dut_o = 9'd0;
            2:       dut_o = ({1'b0, dut_a} + {1'b0, dut_b}) ^ 9'h001;
            default: dut_o = {1'b0, dut_a} + {1'b0, dut_b};
        endcase
    end

    add8_err_meter u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .dut_a   (dut_a),
        .dut_b   (dut_b),
        .dut_o   (dut_o),
        .err_sum (err_sum),
        .wce     (wce),
        .err_cnt (err_cnt)
`ifdef ADD8_ERR_METER_HD_EN
        ,
        .hd_sum  (hd_sum)
`endif
    );

    // Reference statistics over the first n pairs of a sweep, for adder mode m
    function automatic stats_t model(int m, int n);
        stats_t s;
        s.es = 0; s.wce = 0; s.ec = 0; s.hd = 0;
        for (int i = 0; i < n; i++) begin
            int a, b, ex, o, e;
            a  = i >> 8;
            b  = i & 255;
            ex = a + b;
            o  = (m == 1) ? 0 : ((m == 2) ? (ex ^ 1) : ex);
            e  = o - ex;
            if (e < 0) e = -e;
            s.es += e;
            if (e > s.wce) s.wce = e;
            if (e != 0) s.ec++;
            s.hd += $countones(o ^ ex);
        end
        return s;
    endfunction

    // Pulse start so that the next rising edge samples it; returns just after that edge
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        stats_t e;
        rst = 1'b1; start = 1'b0; mode = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb_q.push_back(model(0, 0));
        @(negedge clk);
        e = sb_q.pop_front();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_tests++; if (dut_a !== 8'd0 || dut_b !== 8'd0) begin n_fail++; $display("FAIL reset_ops got %0h/%0h want 0/0", dut_a, dut_b); end
        n_tests++; if (err_sum !== 25'(e.es)) begin n_fail++; $display("FAIL reset_err_sum got %0d want %0d", err_sum, e.es); end
        n_tests++; if (wce !== 9'(e.wce)) begin n_fail++; $display("FAIL reset_wce got %0d want %0d", wce, e.wce); end
        n_tests++; if (err_cnt !== 17'(e.ec)) begin n_fail++; $display("FAIL reset_err_cnt got %0d want %0d", err_cnt, e.ec); end
`ifdef ADD8_ERR_METER_HD_EN
        n_tests++; if (hd_sum !== 20'(e.hd)) begin n_fail++; $display("FAIL reset_hd_sum got %0d want %0d", hd_sum, e.hd); end
`endif
    endtask

    // Partial live statistics with a zero-output adder, then reset 100 cycles into the sweep
    task automatic test_rst_mid_sweep();
        stats_t e;
        mode = 1;
        pulse_start();
        n_tests++; if (busy !== 1'b1 || dut_a !== 8'd0 || dut_b !== 8'd0) begin
            n_fail++; $display("FAIL start_first_pair got busy=%0b %0h/%0h want 1 0/0", busy, dut_a, dut_b);
        end
        sb_q.push_back(model(1, 99));
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            n_tests++; if ({dut_a, dut_b} !== 16'(k)) begin
                n_fail++; $display("FAIL operand_seq k=%0d got %0h want %0h", k, {dut_a, dut_b}, k);
            end
        end
        e = sb_q.pop_front();
        n_tests++; if (err_sum !== 25'(e.es)) begin n_fail++; $display("FAIL live_err_sum got %0d want %0d", err_sum, e.es); end
        n_tests++; if (wce !== 9'(e.wce)) begin n_fail++; $display("FAIL live_wce got %0d want %0d", wce, e.wce); end
        n_tests++; if (err_cnt !== 17'(e.ec)) begin n_fail++; $display("FAIL live_err_cnt got %0d want %0d", err_cnt, e.ec); end
`ifdef ADD8_ERR_METER_HD_EN
        n_tests++; if (hd_sum !== 20'(e.hd)) begin n_fail++; $display("FAIL live_hd_sum got %0d want %0d", hd_sum, e.hd); end
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_flags got busy=%0b done=%0b want 0 0", busy, done); end
        n_tests++; if (dut_a !== 8'd0 || dut_b !== 8'd0) begin n_fail++; $display("FAIL abort_ops got %0h/%0h want 0/0", dut_a, dut_b); end
        n_tests++; if (err_sum !== 25'd0 || wce !== 9'd0 || err_cnt !== 17'd0) begin
            n_fail++; $display("FAIL abort_stats got %0d/%0d/%0d want 0/0/0", err_sum, wce, err_cnt);
        end
`ifdef ADD8_ERR_METER_HD_EN
        n_tests++; if (hd_sum !== 20'd0) begin n_fail++; $display("FAIL abort_hd_sum got %0d want 0", hd_sum); end
`endif
    endtask

    // Full sweep with LSB-inverted adder, start re-pulsed at cycle 1000 (must be ignored)
    task automatic test_full_sweep();
        stats_t e;
        int cyc;
        mode = 2;
        pulse_start();
        sb_q.push_back(model(2, 65536));
        cyc = 0;
        while (!done && cyc < 70000) begin
            if (cyc == 999) start = 1'b1;
            @(negedge clk);
            cyc++;
            if (cyc == 1000) begin
                start = 1'b0;
                n_tests++; if (busy !== 1'b1 || {dut_a, dut_b} !== 16'd1000) begin
                    n_fail++; $display("FAIL restart_ignored got busy=%0b ops=%0h want 1 3e8", busy, {dut_a, dut_b});
                end
            end
        end
        n_tests++; if (cyc !== 65537) begin n_fail++; $display("FAIL done_latency got %0d want 65537", cyc); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_busy got %0b want 0", busy); end
        e = sb_q.pop_front();
        n_tests++; if (err_sum !== 25'(e.es)) begin n_fail++; $display("FAIL full_err_sum got %0d want %0d", err_sum, e.es); end
        n_tests++; if (wce !== 9'(e.wce)) begin n_fail++; $display("FAIL full_wce got %0d want %0d", wce, e.wce); end
        n_tests++; if (err_cnt !== 17'(e.ec)) begin n_fail++; $display("FAIL full_err_cnt got %0d want %0d", err_cnt, e.ec); end
`ifdef ADD8_ERR_METER_HD_EN
        n_tests++; if (hd_sum !== 20'(e.hd)) begin n_fail++; $display("FAIL full_hd_sum got %0d want %0d", hd_sum, e.hd); end
`endif
        repeat (5) @(negedge clk);
        n_tests++; if (done !== 1'b1 || err_sum !== 25'(e.es) || err_cnt !== 17'(e.ec)) begin
            n_fail++; $display("FAIL frozen got done=%0b err_sum=%0d err_cnt=%0d want 1 %0d %0d", done, err_sum, err_cnt, e.es, e.ec);
        end
    endtask

    // Start in DONE clears statistics and reruns the sweep
    task automatic test_restart_in_done();
        stats_t e;
        mode = 1;
        pulse_start();
        n_tests++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rerun_flags got done=%0b busy=%0b want 0 1", done, busy); end
        n_tests++; if (dut_a !== 8'd0 || dut_b !== 8'd0) begin n_fail++; $display("FAIL rerun_ops got %0h/%0h want 0/0", dut_a, dut_b); end
        n_tests++; if (err_sum !== 25'd0 || wce !== 9'd0 || err_cnt !== 17'd0) begin
            n_fail++; $display("FAIL rerun_clear got %0d/%0d/%0d want 0/0/0", err_sum, wce, err_cnt);
        end
`ifdef ADD8_ERR_METER_HD_EN
        n_tests++; if (hd_sum !== 20'd0) begin n_fail++; $display("FAIL rerun_hd_clear got %0d want 0", hd_sum); end
`endif
        sb_q.push_back(model(1, 599));
        repeat (600) @(negedge clk);
        e = sb_q.pop_front();
        n_tests++; if (err_sum !== 25'(e.es)) begin n_fail++; $display("FAIL rerun_err_sum got %0d want %0d", err_sum, e.es); end
        n_tests++; if (wce !== 9'(e.wce)) begin n_fail++; $display("FAIL rerun_wce got %0d want %0d", wce, e.wce); end
        n_tests++; if (err_cnt !== 17'(e.ec)) begin n_fail++; $display("FAIL rerun_err_cnt got %0d want %0d", err_cnt, e.ec); end
`ifdef ADD8_ERR_METER_HD_EN
        n_tests++; if (hd_sum !== 20'(e.hd)) begin n_fail++; $display("FAIL rerun_hd_sum got %0d want %0d", hd_sum, e.hd); end
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_rst_mid_sweep();
        test_full_sweep();
        test_restart_in_done();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
